// File: rtl/sp_sram_arbiter_if.sv
// rtl/sp_sram_arbiter_if.sv - requester and SRAM pin bundle for the single-port SRAM arbiter
interface sp_sram_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int BW = (DATA_WIDTH + 7) / 8;

    logic [NUM_PORTS-1:0]                 req_i;
    logic [NUM_PORTS-1:0]                 we_i;
    logic [NUM_PORTS-1:0][AW-1:0]         addr_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS-1:0][BW-1:0]         be_i;
    logic [NUM_PORTS-1:0]                 gnt_o;
    logic [NUM_PORTS-1:0]                 rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o;

    logic                                 sram_req_o;
    logic                                 sram_we_o;
    logic [AW-1:0]                        sram_addr_o;
    logic [DATA_WIDTH-1:0]                sram_wdata_o;
    logic [BW-1:0]                        sram_be_o;
    logic [DATA_WIDTH-1:0]                sram_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );
endinterface

// File: rtl/sp_sram_arbiter.sv
// rtl/sp_sram_arbiter.sv - round-robin / fixed-priority arbiter sharing one single-port SRAM
module sp_sram_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    sp_sram_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_PORTS);
    typedef logic [PW-1:0] idx_t;

    idx_t ptr_q, ptr_d;
    logic gnt_valid;
    idx_t gnt_idx;
    idx_t cand;
    int   pos;

    logic rsp_valid_q;
    idx_t rsp_port_q;
    logic rsp_we_q;

    // Search starts at ptr_q (or 0 for fixed priority); first requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (FIXED_PRIO != 0) begin
                pos = k;
            end else begin
                pos = int'(ptr_q) + k;
                if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            end
            cand = idx_t'(pos);
            if (!gnt_valid && bus.req_i[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        bus.gnt_o        = '0;
        bus.sram_req_o   = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = '0;
        if (gnt_valid) begin
            bus.gnt_o[gnt_idx] = 1'b1;
            bus.sram_req_o     = 1'b1;
            bus.sram_we_o      = bus.we_i[gnt_idx];
            bus.sram_addr_o    = bus.addr_i[gnt_idx];
            bus.sram_wdata_o   = bus.wdata_i[gnt_idx];
            bus.sram_be_o      = bus.be_i[gnt_idx];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((FIXED_PRIO == 0) && gnt_valid) begin
            ptr_d = (gnt_idx == idx_t'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Tag of the transaction granted last cycle; the SRAM answers it this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= '0;
            rsp_we_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= gnt_valid;
            rsp_port_q  <= gnt_idx;
            rsp_we_q    <= gnt_valid & bus.we_i[gnt_idx];
        end
    end

    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        if (rsp_valid_q) begin
            bus.rvalid_o[rsp_port_q] = 1'b1;
            if (!rsp_we_q) bus.rdata_o[rsp_port_q] = bus.sram_rdata_i;
        end
    end
endmodule

// File: tb/tb_sp_sram_arbiter.sv
// tb/tb_sp_sram_arbiter.sv - directed self-checking bench for sp_sram_arbiter
module tb_sp_sram_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem [1024];
    logic [31:0] rd_rr;
    logic [31:0] rd_fp;

    sp_sram_arbiter_if #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024)) bus_rr ();
    sp_sram_arbiter_if #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024)) bus_fp ();

    sp_sram_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024), .FIXED_PRIO(0)) dut_rr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_rr.slave)
    );

    sp_sram_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .NUM_WORDS(1024), .FIXED_PRIO(1)) dut_fp (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_fp.slave)
    );

    always #5 clk = ~clk;

    // SRAM macro model: byte-masked write at the grant edge, read data one cycle later.
    always @(posedge clk) begin
        if (bus_rr.sram_req_o) begin
            if (bus_rr.sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus_rr.sram_be_o[b]) mem[bus_rr.sram_addr_o][8*b +: 8] <= bus_rr.sram_wdata_o[8*b +: 8];
            end else begin
                rd_rr <= mem[bus_rr.sram_addr_o];
            end
        end
    end

    always @(posedge clk) rd_fp <= 32'h5A5A_0000 | {22'h0, bus_fp.sram_addr_o};

    assign bus_rr.sram_rdata_i = rd_rr;
    assign bus_fp.sram_rdata_i = rd_fp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_rr(input logic [1:0] req, input logic [1:0] we,
                            input logic [9:0] a0, input logic [9:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] b0, input logic [3:0] b1);
        bus_rr.req_i   = req;
        bus_rr.we_i    = we;
        bus_rr.addr_i  = {a1, a0};
        bus_rr.wdata_i = {d1, d0};
        bus_rr.be_i    = {b1, b0};
    endtask

    task automatic drive_fp(input logic [1:0] req, input logic [9:0] a0, input logic [9:0] a1);
        bus_fp.req_i   = req;
        bus_fp.we_i    = 2'b00;
        bus_fp.addr_i  = {a1, a0};
        bus_fp.wdata_i = '0;
        bus_fp.be_i    = {4'hF, 4'hF};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        drive_fp(2'b00, 10'h0, 10'h0);
        #1;
        check("reset_gnt", bus_rr.gnt_o, 2'b00);
        check("reset_rvalid", bus_rr.rvalid_o, 2'b00);
        check("reset_rdata", bus_rr.rdata_o, 64'h0);
        check("reset_sram_req", bus_rr.sram_req_o, 1'b0);
        check("reset_sram_addr", bus_rr.sram_addr_o, 10'h0);
        check("reset_ptr", dut_rr.ptr_q, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        // Single write then read on port 0.
        drive_rr(2'b01, 2'b01, 10'h010, 10'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        check("wr_gnt", bus_rr.gnt_o, 2'b01);
        check("wr_sram_we", bus_rr.sram_we_o, 1'b1);
        check("wr_sram_addr", bus_rr.sram_addr_o, 10'h010);
        check("wr_sram_wdata", bus_rr.sram_wdata_o, 32'hDEADBEEF);
        check("wr_sram_be", bus_rr.sram_be_o, 4'hF);
        next_cycle();
        drive_rr(2'b01, 2'b00, 10'h010, 10'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        check("rd_gnt", bus_rr.gnt_o, 2'b01);
        check("wr_rvalid", bus_rr.rvalid_o, 2'b01);
        check("wr_rdata_zero", bus_rr.rdata_o, 64'h0);
        check("rd_sram_we", bus_rr.sram_we_o, 1'b0);
        next_cycle();
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("rd_rvalid", bus_rr.rvalid_o, 2'b01);
        check("rd_rdata", bus_rr.rdata_o, {32'h0, 32'hDEADBEEF});
        check("idle_gnt", bus_rr.gnt_o, 2'b00);
        check("idle_sram_req", bus_rr.sram_req_o, 1'b0);
        check("idle_sram_wdata", bus_rr.sram_wdata_o, 32'h0);
        check("ptr_after_p0", dut_rr.ptr_q, 1'b1);
        next_cycle();
        @(negedge clk);
        check("no_extra_rvalid", bus_rr.rvalid_o, 2'b00);
        next_cycle();

        // Reset in the cycle after a read grant drops the response.
        drive_rr(2'b01, 2'b00, 10'h010, 10'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        check("rstmid_gnt", bus_rr.gnt_o, 2'b01);
        next_cycle();
        rst_n = 1'b0;
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        check("rstmid_rvalid_now", bus_rr.rvalid_o, 2'b00);
        check("rstmid_ptr", dut_rr.ptr_q, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_rvalid_after", bus_rr.rvalid_o, 2'b00);
        next_cycle();
        drive_rr(2'b10, 2'b00, 10'h0, 10'h010, 32'h0, 32'h0, 4'h0, 4'hF);
        @(negedge clk);
        check("postrst_gnt_p1", bus_rr.gnt_o, 2'b10);
        check("postrst_rvalid", bus_rr.rvalid_o, 2'b00);
        next_cycle();
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("postrst_rvalid_p1", bus_rr.rvalid_o, 2'b10);
        check("postrst_rdata", bus_rr.rdata_o, {32'hDEADBEEF, 32'h0});
        next_cycle();

        // Round-robin contention: both ports hold reads for 4 cycles.
        drive_rr(2'b11, 2'b00, 10'h010, 10'h010, 32'h0, 32'h0, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_gnt", bus_rr.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 0) check("rr_rvalid", bus_rr.rvalid_o, 2'b00);
            else check("rr_rvalid", bus_rr.rvalid_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) check("rr_rdata", bus_rr.rdata_o,
                             (i % 2 == 0) ? {32'hDEADBEEF, 32'h0} : {32'h0, 32'hDEADBEEF});
            next_cycle();
        end
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("rr_last_rvalid", bus_rr.rvalid_o, 2'b10);
        check("rr_ptr_end", dut_rr.ptr_q, 1'b0);
        next_cycle();

        // Byte enables, including a be=0 no-op write from port 1.
        drive_rr(2'b01, 2'b01, 10'd5, 10'h0, 32'h11223344, 32'h0, 4'hF, 4'h0);
        next_cycle();
        drive_rr(2'b01, 2'b01, 10'd5, 10'h0, 32'hAABBCCDD, 32'h0, 4'h5, 4'h0);
        @(negedge clk);
        check("be_sram_be", bus_rr.sram_be_o, 4'h5);
        next_cycle();
        drive_rr(2'b10, 2'b10, 10'h0, 10'd5, 32'h0, 32'hFFFFFFFF, 4'h0, 4'h0);
        next_cycle();
        drive_rr(2'b01, 2'b00, 10'd5, 10'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        check("be0_rvalid", bus_rr.rvalid_o, 2'b10);
        check("be0_rdata", bus_rr.rdata_o, 64'h0);
        next_cycle();
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("be_rdata", bus_rr.rdata_o, {32'h0, 32'h11BB33DD});
        next_cycle();

        // Read-after-write across ports on consecutive cycles.
        drive_rr(2'b10, 2'b10, 10'h0, 10'd7, 32'h0, 32'h0000CAFE, 4'h0, 4'hF);
        @(negedge clk);
        check("raw_wr_gnt", bus_rr.gnt_o, 2'b10);
        next_cycle();
        drive_rr(2'b01, 2'b00, 10'd7, 10'h0, 32'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        check("raw_rd_gnt", bus_rr.gnt_o, 2'b01);
        check("raw_wr_rvalid", bus_rr.rvalid_o, 2'b10);
        check("raw_rdata1_n1", bus_rr.rdata_o[1], 32'h0);
        next_cycle();
        drive_rr(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("raw_rd_rvalid", bus_rr.rvalid_o, 2'b01);
        check("raw_rdata0", bus_rr.rdata_o[0], 32'h0000CAFE);
        check("raw_rdata1_n2", bus_rr.rdata_o[1], 32'h0);
        next_cycle();

        // Fixed priority: port 0 wins while it requests.
        drive_fp(2'b11, 10'd3, 10'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fp_gnt", bus_fp.gnt_o, 2'b01);
            if (i > 0) check("fp_rdata", bus_fp.rdata_o, {32'h0, 32'h5A5A0003});
            next_cycle();
        end
        drive_fp(2'b10, 10'd3, 10'd9);
        @(negedge clk);
        check("fp_gnt_p1", bus_fp.gnt_o, 2'b10);
        check("fp_rvalid_p0", bus_fp.rvalid_o, 2'b01);
        next_cycle();
        drive_fp(2'b00, 10'd0, 10'd0);
        @(negedge clk);
        check("fp_rvalid_p1", bus_fp.rvalid_o, 2'b10);
        check("fp_rdata_p1", bus_fp.rdata_o, {32'h5A5A0009, 32'h0});
        check("fp_ptr_unused", dut_fp.ptr_q, 1'b0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
